flow_rate_monitor: RTL and testbench

//  Downstream of the tx/rx RAM-update + divider stage: consumes per-flow results {id, send rate, ack gap}.

---
 rtl/flow_rate_monitor_pkg.sv | 55 +++++
 rtl/frm_sync_fifo.sv | 60 ++++++
 rtl/flow_rate_monitor.sv | 193 +++++++++++++++++++
 tb/tb_flow_rate_monitor.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/flow_rate_monitor_pkg.sv
// Shared definitions for the flow rate monitor.
//   - Field widths and default tuning values (EWMA weight, alarm threshold).
//   - entry_t : one table entry {tag, ewma, count}, 61 bits.
//   - sample_t: one buffered input sample {id, send_r, derta_ack}, 87 bits.
//   - state_e : report FSM state encoding.
//   - ewma_step(): one EWMA update step.
package flow_rate_monitor_pkg;

    localparam int C_ID_WIDTH        = 23;
    localparam int C_IDX_WIDTH       = 10;
    localparam int C_TAG_WIDTH       = C_ID_WIDTH - C_IDX_WIDTH;
    localparam int C_RATE_WIDTH      = 32;
    localparam int C_CNT_WIDTH       = 16;
    localparam int C_EWMA_SHIFT      = 3;
    localparam int C_ACK_THRESH      = 1000;
    localparam int C_FIFO_DEPTH_BITS = 6;
    localparam int C_TABLE_DEPTH     = 1 << C_IDX_WIDTH;

    typedef struct packed {
        logic [C_TAG_WIDTH-1:0]  tag;
        logic [C_RATE_WIDTH-1:0] ewma;
        logic [C_CNT_WIDTH-1:0]  count;
    } entry_t;

    typedef struct packed {
        logic [C_ID_WIDTH-1:0]   id;
        logic [C_RATE_WIDTH-1:0] send_r;
        logic [C_RATE_WIDTH-1:0] derta_ack;
    } sample_t;

    localparam int C_SAMPLE_WIDTH = $bits(sample_t);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_UPDATE = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    // ewma + ((sample - ewma) >>> shift). The difference is formed as a
    // 33-bit signed value so both unsigned operands fit; the result always
    // lies between ewma and sample, so dropping bit 32 loses nothing.
    function automatic logic [C_RATE_WIDTH-1:0] ewma_step(
        input logic [C_RATE_WIDTH-1:0] old_v,
        input logic [C_RATE_WIDTH-1:0] sample,
        input int                      shift
    );
        logic signed [C_RATE_WIDTH:0] diff;
        logic signed [C_RATE_WIDTH:0] sum;
        diff = $signed({1'b0, sample}) - $signed({1'b0, old_v});
        sum  = $signed({1'b0, old_v}) + (diff >>> shift);
        return sum[C_RATE_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/frm_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
//   clk, rst_n    : clock, asynchronous active-low reset (empties the FIFO)
//   push/push_data: write request; ignored when full unless popping this cycle
//   pop           : consume head_data; ignored when empty
//   head_data     : current head entry, valid whenever !empty
//   empty, full   : status
module frm_sync_fifo
    import flow_rate_monitor_pkg::*;
#(
    parameter int W          = C_SAMPLE_WIDTH,
    parameter int DEPTH_BITS = C_FIFO_DEPTH_BITS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         empty,
    output logic         full
);

    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [W-1:0]        mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [DEPTH_BITS:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS:0] rd_ptr_q, rd_ptr_d;
    logic                wr_en, rd_en;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[DEPTH_BITS] != rd_ptr_q[DEPTH_BITS]) &&
                   (wr_ptr_q[DEPTH_BITS-1:0] == rd_ptr_q[DEPTH_BITS-1:0]);
        rd_en    = pop && !empty;
        // A pop in the same cycle frees the slot being written.
        wr_en    = push && (!full || rd_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + (DEPTH_BITS+1)'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + (DEPTH_BITS+1)'(1);
    end

    assign head_data = mem[rd_ptr_q[DEPTH_BITS-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q[DEPTH_BITS-1:0]] <= push_data;
    end

endmodule

// File: rtl/flow_rate_monitor.sv
// Per-flow send-rate monitor.
//   Inputs : clk, reset (async active-low), in_math_valid strobe with
//            in_data_id / in_send_r / in_send_f (ignored) / in_derta_ack.
//   Outputs: one report per accepted sample on out_valid/out_ready with
//            id, updated EWMA, saturating count, in-flight, alarm, new-flow;
//            out_drop_cnt counts samples lost to a full input FIFO;
//            dbg_state shows the report FSM state.
// Handshake: a report is transferred on a clock edge where out_valid and
// out_ready are both 1; while out_valid=1 and out_ready=0 every report
// output is held stable. The input side has no backpressure.
module flow_rate_monitor
    import flow_rate_monitor_pkg::*;
#(
    parameter int          P_EWMA_SHIFT = C_EWMA_SHIFT,
    parameter logic [31:0] P_ACK_THRESH = C_ACK_THRESH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_math_valid,
    input  logic [C_ID_WIDTH-1:0]   in_data_id,
    input  logic [C_RATE_WIDTH-1:0] in_send_r,
    input  logic [C_RATE_WIDTH-1:0] in_send_f,
    input  logic [C_RATE_WIDTH-1:0] in_derta_ack,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [C_ID_WIDTH-1:0]   out_id,
    output logic [C_RATE_WIDTH-1:0] out_rate_ewma,
    output logic [C_CNT_WIDTH-1:0]  out_count,
    output logic [C_RATE_WIDTH-1:0] out_inflight,
    output logic                    out_alarm,
    output logic                    out_new_flow,
    output logic [15:0]             out_drop_cnt,
    output state_e                  dbg_state
);

    localparam logic [15:0] DROP_ONE = 16'd1;
    localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = C_CNT_WIDTH'(1);

    sample_t fifo_in, fifo_head;
    logic    fifo_empty, fifo_full, fifo_pop;

    // The remainder carries no information for rate tracking.
    logic unused_send_f;
    assign unused_send_f = ^in_send_f;

    assign fifo_in = '{id: in_data_id, send_r: in_send_r, derta_ack: in_derta_ack};

    frm_sync_fifo #(
        .W         (C_SAMPLE_WIDTH),
        .DEPTH_BITS(C_FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .push     (in_math_valid),
        .push_data(fifo_in),
        .pop      (fifo_pop),
        .head_data(fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    state_e                   state_q, state_d;
    sample_t                  head_q, head_d;
    logic [C_TABLE_DEPTH-1:0] valid_q, valid_d;
    logic                     out_valid_q, out_valid_d;
    logic [C_ID_WIDTH-1:0]    out_id_q, out_id_d;
    logic [C_RATE_WIDTH-1:0]  out_ewma_q, out_ewma_d;
    logic [C_CNT_WIDTH-1:0]   out_count_q, out_count_d;
    logic [C_RATE_WIDTH-1:0]  out_inflight_q, out_inflight_d;
    logic                     out_alarm_q, out_alarm_d;
    logic                     out_new_q, out_new_d;
    logic [15:0]              drop_q, drop_d;

    // Table: data RAM with registered read, validity kept in flops so it
    // can be cleared by reset.
    entry_t                   table_mem [C_TABLE_DEPTH];
    entry_t                   rd_entry_q;
    entry_t                   wr_entry;
    logic                     ram_we, ram_re;
    logic [C_IDX_WIDTH-1:0]   rd_idx, wr_idx;
    logic [C_TAG_WIDTH-1:0]   head_tag;
    logic                     hit;
    logic [C_RATE_WIDTH-1:0]  inflight;

    assign rd_idx   = fifo_head.id[C_IDX_WIDTH-1:0];
    assign wr_idx   = head_q.id[C_IDX_WIDTH-1:0];
    assign head_tag = head_q.id[C_ID_WIDTH-1:C_IDX_WIDTH];
    assign hit      = valid_q[wr_idx] && (rd_entry_q.tag == head_tag);
    // Negative ack gap means nothing outstanding.
    assign inflight = head_q.derta_ack[C_RATE_WIDTH-1] ? '0 : head_q.derta_ack;

    always_comb begin
        state_d        = state_q;
        head_d         = head_q;
        valid_d        = valid_q;
        out_valid_d    = out_valid_q;
        out_id_d       = out_id_q;
        out_ewma_d     = out_ewma_q;
        out_count_d    = out_count_q;
        out_inflight_d = out_inflight_q;
        out_alarm_d    = out_alarm_q;
        out_new_d      = out_new_q;
        fifo_pop       = 1'b0;
        ram_re         = 1'b0;
        ram_we         = 1'b0;
        wr_entry       = '{tag: head_tag, ewma: head_q.send_r, count: CNT_ONE};

        if (hit) begin
            wr_entry.ewma  = ewma_step(rd_entry_q.ewma, head_q.send_r, P_EWMA_SHIFT);
            wr_entry.count = (rd_entry_q.count == '1) ? rd_entry_q.count
                                                      : rd_entry_q.count + CNT_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    head_d   = fifo_head;
                    fifo_pop = 1'b1;
                    ram_re   = 1'b1;
                    state_d  = ST_LOOKUP;
                end
            end
            ST_LOOKUP: state_d = ST_UPDATE;
            ST_UPDATE: begin
                ram_we          = 1'b1;
                valid_d[wr_idx] = 1'b1;
                out_valid_d     = 1'b1;
                out_id_d        = head_q.id;
                out_ewma_d      = wr_entry.ewma;
                out_count_d     = wr_entry.count;
                out_inflight_d  = inflight;
                out_alarm_d     = (inflight > P_ACK_THRESH);
                out_new_d       = !hit;
                state_d         = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        drop_d = drop_q;
        if (in_math_valid && fifo_full && !fifo_pop && (drop_q != '1))
            drop_d = drop_q + DROP_ONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            head_q         <= '0;
            valid_q        <= '0;
            out_valid_q    <= 1'b0;
            out_id_q       <= '0;
            out_ewma_q     <= '0;
            out_count_q    <= '0;
            out_inflight_q <= '0;
            out_alarm_q    <= 1'b0;
            out_new_q      <= 1'b0;
            drop_q         <= '0;
        end else begin
            state_q        <= state_d;
            head_q         <= head_d;
            valid_q        <= valid_d;
            out_valid_q    <= out_valid_d;
            out_id_q       <= out_id_d;
            out_ewma_q     <= out_ewma_d;
            out_count_q    <= out_count_d;
            out_inflight_q <= out_inflight_d;
            out_alarm_q    <= out_alarm_d;
            out_new_q      <= out_new_d;
            drop_q         <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) table_mem[wr_idx] <= wr_entry;
        if (ram_re) rd_entry_q <= table_mem[rd_idx];
    end

    assign out_valid     = out_valid_q;
    assign out_id        = out_id_q;
    assign out_rate_ewma = out_ewma_q;
    assign out_count     = out_count_q;
    assign out_inflight  = out_inflight_q;
    assign out_alarm     = out_alarm_q;
    assign out_new_flow  = out_new_q;
    assign out_drop_cnt  = drop_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_flow_rate_monitor.sv
module tb_flow_rate_monitor;
    import flow_rate_monitor_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        in_math_valid;
    logic [22:0] in_data_id;
    logic [31:0] in_send_r, in_send_f, in_derta_ack;
    logic        out_valid, out_ready;
    logic [22:0] out_id;
    logic [31:0] out_rate_ewma, out_inflight;
    logic [15:0] out_count, out_drop_cnt;
    logic        out_alarm, out_new_flow;
    state_e      dbg_state;

    always #5 clk = ~clk;

    flow_rate_monitor dut (
        .clk          (clk),
        .reset        (reset),
        .in_math_valid(in_math_valid),
        .in_data_id   (in_data_id),
        .in_send_r    (in_send_r),
        .in_send_f    (in_send_f),
        .in_derta_ack (in_derta_ack),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_id       (out_id),
        .out_rate_ewma(out_rate_ewma),
        .out_count    (out_count),
        .out_inflight (out_inflight),
        .out_alarm    (out_alarm),
        .out_new_flow (out_new_flow),
        .out_drop_cnt (out_drop_cnt),
        .dbg_state    (dbg_state)
    );

    typedef struct packed {
        logic [22:0] id;
        logic [31:0] ewma;
        logic [15:0] cnt;
        logic [31:0] infl;
        logic        alarm;
        logic        nf;
    } rpt_t;
    localparam int RW = $bits(rpt_t);

    logic [RW-1:0] exp_q[$];
    int            n_cmp  = 0;
    int            n_fail = 0;
    rpt_t          mon_act;
    logic [127:0]  snap, cur;
    logic          seen;
    int            diffs;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at posedge+1; presents one sample for exactly one cycle.
    task automatic drive(input logic [22:0] id, input logic [31:0] r, input logic [31:0] ack);
        in_math_valid = 1'b1;
        in_data_id    = id;
        in_send_r     = r;
        in_send_f     = $urandom;
        in_derta_ack  = ack;
        @(posedge clk);
        #1;
        in_math_valid = 1'b0;
    endtask

    task automatic expect_rpt(input logic [22:0] id, input logic [31:0] ewma, input logic [15:0] cnt,
                              input logic [31:0] infl, input logic alarm, input logic nf);
        rpt_t e;
        e = '{id: id, ewma: ewma, cnt: cnt, infl: infl, alarm: alarm, nf: nf};
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [22:0] id, input logic [31:0] r, input logic [31:0] ack,
                        input logic [31:0] ewma, input logic [15:0] cnt, input logic [31:0] infl,
                        input logic alarm, input logic nf);
        expect_rpt(id, ewma, cnt, infl, alarm, nf);
        drive(id, r, ack);
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d reports outstanding, required 0", name, exp_q.size());
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            mon_act = '{id: out_id, ewma: out_rate_ewma, cnt: out_count,
                        infl: out_inflight, alarm: out_alarm, nf: out_new_flow};
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL report_unexpected: got %h required none", mon_act);
            end else begin
                check("report", 128'(mon_act), 128'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        reset         = 1'b0;
        in_math_valid = 1'b0;
        in_data_id    = '0;
        in_send_r     = '0;
        in_send_f     = '0;
        in_derta_ack  = '0;
        out_ready     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 128'({out_valid, out_id, out_rate_ewma, out_count, out_inflight,
                                    out_alarm, out_new_flow, out_drop_cnt}), 128'(0));
        check("reset_state", 128'(dbg_state), 128'(ST_IDLE));
        reset = 1'b1;
        @(posedge clk);
        #1;

        // First sample: latency 4 from the strobe cycle.
        send(23'h000005, 32'd800, 32'd10, 32'd800, 16'd1, 32'd10, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("latency_t3_not_valid", 128'(out_valid), 128'(0));
        @(posedge clk);
        #1;
        check("latency_t4_valid", 128'(out_valid), 128'(1));
        wait_drain("drain_first", 50);

        // EWMA hits, alarm thresholds, tag replacement, extremes.
        send(23'h000005, 32'd1600, 32'd1001, 32'd900, 16'd2, 32'd1001, 1'b1, 1'b0); gap();
        send(23'h000005, 32'd0, 32'd1000, 32'd787, 16'd3, 32'd1000, 1'b0, 1'b0); gap();
        send(23'h000405, 32'd5000, 32'hFFFF_FFF0, 32'd5000, 16'd1, 32'd0, 1'b0, 1'b1); gap();
        send(23'h000005, 32'd100, 32'd0, 32'd100, 16'd1, 32'd0, 1'b0, 1'b1); gap();
        send(23'h000005, 32'd260, 32'd5, 32'd120, 16'd2, 32'd5, 1'b0, 1'b0); gap();
        send(23'h7FFFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 16'd1, 32'h7FFF_FFFF, 1'b1, 1'b1); gap();
        send(23'h7FFFFF, 32'd0, 32'd1001, 32'hDFFF_FFFF, 16'd2, 32'd1001, 1'b1, 1'b0);
        wait_drain("drain_directed", 400);
        check("drop_cnt_none", 128'(out_drop_cnt), 128'(0));

        // Backpressure burst: sample 0 sits in the FSM, 1..64 fill the
        // FIFO, 65..69 are dropped.
        out_ready = 1'b0;
        seen      = 1'b0;
        diffs     = 0;
        fork
            begin
                for (int i = 0; i < 70; i++) begin
                    if (i <= 64)
                        expect_rpt(23'h000100 + 23'(i), 32'd1000 + 32'(i * 3), 16'd1,
                                   32'(i * 20), (i * 20) > 1000, 1'b1);
                    drive(23'h000100 + 23'(i), 32'd1000 + 32'(i * 3), 32'(i * 20));
                end
            end
            begin
                repeat (100) begin
                    @(posedge clk);
                    #1;
                    cur = 128'({out_valid, out_id, out_rate_ewma, out_count, out_inflight,
                                out_alarm, out_new_flow});
                    if (seen) begin
                        if (cur !== snap) diffs++;
                    end else if (out_valid) begin
                        seen = 1'b1;
                        snap = cur;
                    end
                end
            end
        join
        check("hold_seen_valid", 128'(seen), 128'(1));
        check("hold_stable", 128'(diffs), 128'(0));
        check("drop_cnt_burst", 128'(out_drop_cnt), 128'(5));
        out_ready = 1'b1;
        wait_drain("drain_burst", 1000);
        check("drop_cnt_after", 128'(out_drop_cnt), 128'(5));

        // Reset while the FSM is in LOOKUP.
        drive(23'h00002A, 32'd55, 32'd1);
        @(posedge clk);
        #1;
        check("state_lookup", 128'(dbg_state), 128'(ST_LOOKUP));
        reset = 1'b0;
        #1;
        check("reset_mid_outputs", 128'({out_valid, out_id, out_rate_ewma, out_count, out_inflight,
                                        out_alarm, out_new_flow, out_drop_cnt}), 128'(0));
        check("reset_mid_state", 128'(dbg_state), 128'(ST_IDLE));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        send(23'h000005, 32'd42, 32'd3, 32'd42, 16'd1, 32'd3, 1'b0, 1'b1); gap();
        send(23'h00002A, 32'd7, 32'd2000, 32'd7, 16'd1, 32'd2000, 1'b1, 1'b1);
        wait_drain("drain_after_reset", 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
